// File: rtl/rat_recovery_seq_pkg.sv
// Shared types and sizing for the flush-recovery sequencer.
// Optional feature macro: RAT_REC_SKIP_EN (priority-encoded free-list rebuild).
package rv32i_types;

    localparam int SS          = 2;
    localparam int ARCH_REGS   = 32;
    localparam int PHYS_REGS   = 64;
    localparam int PW          = $clog2(PHYS_REGS);
    localparam int AW          = $clog2(ARCH_REGS);
    localparam int COPY_WIDTH  = 4;
    localparam int COPY_CYCLES = ARCH_REGS / COPY_WIDTH;
    localparam int CPW         = $clog2(COPY_CYCLES);
    localparam int SPW         = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COPY    = 2'd1,
        REBUILD = 2'd2,
        DONE    = 2'd3
    } rec_state_t;

    // OR every snapshot entry into a one-hot-per-register bitmap; duplicates collapse.
    function automatic logic [PHYS_REGS-1:0] build_mapped(
        input logic [ARCH_REGS-1:0][PW-1:0] map
    );
        logic [PHYS_REGS-1:0] bits;
        bits = '0;
        for (int i = 0; i < ARCH_REGS; i++) begin
            bits[map[i]] = 1'b1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/rat_recovery_seq_phys_free_scanner.sv
// Walks the physical register space and offers every register not present in
// the committed map to the free list, in ascending order.
// Optional feature macro: RAT_REC_SKIP_EN jumps straight to the next free
// register instead of visiting every index.
module phys_free_scanner
    import rv32i_types::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [ARCH_REGS-1:0][PW-1:0]  map_in,
    input  logic                          active,
    input  logic                          push_ready,
    output logic                          push_valid,
    output logic [PW-1:0]                 push_data,
    output logic                          scan_end
);

    logic [PHYS_REGS-1:0] mapped_q, mapped_d;
    logic [SPW-1:0]       scan_ptr_q, scan_ptr_d;

`ifdef RAT_REC_SKIP_EN
    logic [PHYS_REGS-1:0] cand;
    logic [PHYS_REGS-1:0] rest;
    logic [PW-1:0]        first_free;
    logic                 found;
    logic                 more;

    // Pick the lowest unmapped register at or above scan_ptr and tell whether another follows it.
    always_comb begin
        cand       = '0;
        first_free = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            cand[i] = !mapped_q[i] && (SPW'(i) >= scan_ptr_q);
        end
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                first_free = PW'(i);
            end
        end
        found            = |cand;
        rest             = cand;
        rest[first_free] = 1'b0;
        more             = |rest;

        push_valid = active && found;
        push_data  = first_free;
        scan_end   = active && (!found || (push_ready && !more));

        mapped_d   = load ? build_mapped(map_in) : mapped_q;
        scan_ptr_d = scan_ptr_q;
        if (load) begin
            scan_ptr_d = '0;
        end else if (active && found && push_ready) begin
            scan_ptr_d = {1'b0, first_free} + SPW'(1);
        end
    end
`else
    logic [PW-1:0] cur_idx;
    logic          advance;

    // Visit one index per cycle; a free register holds the pointer until the free list accepts it.
    always_comb begin
        cur_idx    = scan_ptr_q[PW-1:0];
        push_valid = active && !mapped_q[cur_idx];
        push_data  = cur_idx;
        advance    = active && (mapped_q[cur_idx] || push_ready);
        scan_end   = advance && (scan_ptr_q == SPW'(PHYS_REGS - 1));

        mapped_d   = load ? build_mapped(map_in) : mapped_q;
        scan_ptr_d = scan_ptr_q;
        if (load) begin
            scan_ptr_d = '0;
        end else if (advance) begin
            scan_ptr_d = scan_ptr_q + SPW'(1);
        end
    end
`endif

    // Bitmap and scan pointer registers, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mapped_q   <= '0;
            scan_ptr_q <= '0;
        end else begin
            mapped_q   <= mapped_d;
            scan_ptr_q <= scan_ptr_d;
        end
    end

endmodule

// File: rtl/rat_recovery_seq.sv
// Flush-recovery sequencer: snapshots the retired RAT on a mispredict, copies
// it into the speculative RAT, then rebuilds the free list from the unmapped
// physical registers while holding rename stalled.
// Optional feature macro: RAT_REC_SKIP_EN (selected inside phys_free_scanner).
module rat_recovery_seq
    import rv32i_types::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_req,
    input  logic [ARCH_REGS-1:0][PW-1:0]      backup_retired_rat,
    output logic                              stall,
    output logic [COPY_WIDTH-1:0]             rat_wr_en,
    output logic [COPY_WIDTH-1:0][AW-1:0]     rat_wr_idx,
    output logic [COPY_WIDTH-1:0][PW-1:0]     rat_wr_data,
    output logic                              fl_clear,
    output logic                              fl_push,
    output logic [PW-1:0]                     fl_push_data,
    input  logic                              fl_push_ready,
    output logic                              recovery_done
);

    rec_state_t                   state_q, state_d;
    logic [ARCH_REGS-1:0][PW-1:0] snap_q, snap_d;
    logic [CPW-1:0]               copy_ptr_q, copy_ptr_d;

    logic          scan_load;
    logic          scan_active;
    logic          scan_push_valid;
    logic [PW-1:0] scan_push_data;
    logic          scan_end;

    assign scan_load   = (state_q == IDLE) && flush_req;
    assign scan_active = (state_q == REBUILD);

    phys_free_scanner u_scanner (
        .clk        (clk),
        .rst        (rst),
        .load       (scan_load),
        .map_in     (backup_retired_rat),
        .active     (scan_active),
        .push_ready (fl_push_ready),
        .push_valid (scan_push_valid),
        .push_data  (scan_push_data),
        .scan_end   (scan_end)
    );

    // Next-state logic; a flush outside IDLE is ignored because the pipeline is already drained.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        copy_ptr_d = copy_ptr_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d    = COPY;
                    snap_d     = backup_retired_rat;
                    copy_ptr_d = '0;
                end
            end
            COPY: begin
                copy_ptr_d = copy_ptr_q + CPW'(1);
                if (copy_ptr_q == CPW'(COPY_CYCLES - 1)) begin
                    state_d = REBUILD;
                end
            end
            REBUILD: begin
                if (scan_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, except stall which must cover the flush cycle itself.
    always_comb begin
        stall         = flush_req || (state_q != IDLE);
        rat_wr_en     = '0;
        rat_wr_idx    = '0;
        rat_wr_data   = '0;
        fl_clear      = (state_q == COPY) && (copy_ptr_q == '0);
        fl_push       = scan_push_valid;
        fl_push_data  = scan_push_valid ? scan_push_data : '0;
        recovery_done = (state_q == DONE);
        if (state_q == COPY) begin
            for (int k = 0; k < COPY_WIDTH; k++) begin
                rat_wr_en[k]   = 1'b1;
                rat_wr_idx[k]  = AW'(copy_ptr_q) * AW'(COPY_WIDTH) + AW'(k);
                rat_wr_data[k] = snap_q[rat_wr_idx[k]];
            end
        end
    end

    // State, snapshot and copy pointer registers with active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            copy_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            copy_ptr_q <= copy_ptr_d;
        end
    end

endmodule

// File: tb/tb_rat_recovery_seq.sv
// Directed self-checking bench for rat_recovery_seq.
// Build with +define+RAT_REC_SKIP_EN to check the priority-encoded rebuild timing.
module tb_rat_recovery_seq;
    import rv32i_types::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush_req;
    logic [ARCH_REGS-1:0][PW-1:0]  backup_retired_rat;
    logic                          stall;
    logic [COPY_WIDTH-1:0]         rat_wr_en;
    logic [COPY_WIDTH-1:0][AW-1:0] rat_wr_idx;
    logic [COPY_WIDTH-1:0][PW-1:0] rat_wr_data;
    logic                          fl_clear;
    logic                          fl_push;
    logic [PW-1:0]                 fl_push_data;
    logic                          fl_push_ready;
    logic                          recovery_done;

    int checks = 0;
    int errors = 0;

    logic [ARCH_REGS-1:0][PW-1:0] test_map;
    int exp_push[$];
    int got_push[$];

    always #5 clk = ~clk;

    rat_recovery_seq dut (
        .clk                (clk),
        .rst                (rst),
        .flush_req          (flush_req),
        .backup_retired_rat (backup_retired_rat),
        .stall              (stall),
        .rat_wr_en          (rat_wr_en),
        .rat_wr_idx         (rat_wr_idx),
        .rat_wr_data        (rat_wr_data),
        .fl_clear           (fl_clear),
        .fl_push            (fl_push),
        .fl_push_data       (fl_push_data),
        .fl_push_ready      (fl_push_ready),
        .recovery_done      (recovery_done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All outputs must read as their reset/idle values.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ":stall"}, 32'(stall), 0);
        checkOutput({tag, ":rat_wr_en"}, 32'(rat_wr_en), 0);
        checkOutput({tag, ":rat_wr_idx"}, 32'(rat_wr_idx), 0);
        checkOutput({tag, ":rat_wr_data"}, 32'(rat_wr_data), 0);
        checkOutput({tag, ":fl_clear"}, 32'(fl_clear), 0);
        checkOutput({tag, ":fl_push"}, 32'(fl_push), 0);
        checkOutput({tag, ":fl_push_data"}, 32'(fl_push_data), 0);
        checkOutput({tag, ":recovery_done"}, 32'(recovery_done), 0);
    endtask

    // One full recovery from a flush of test_map; optional backpressure, re-pulse or mid-run reset.
    task automatic applyStimulus(input string name, input int bp_len, input bit repulse, input int reset_at);
        bit used[PHYS_REGS];
        int got_rat[ARCH_REGS];
        int first_push_k;
        int exp_done;
        int got_done;
        int clear_cnt;
        int k;
        bit finished;
        bit stall_dropped;
        bit en_bad;

        exp_push.delete();
        got_push.delete();
        for (int p = 0; p < PHYS_REGS; p++) used[p] = 1'b0;
        for (int i = 0; i < ARCH_REGS; i++) begin
            used[int'(test_map[i])] = 1'b1;
            got_rat[i] = -1;
        end
        for (int p = 0; p < PHYS_REGS; p++) if (!used[p]) exp_push.push_back(p);

`ifdef RAT_REC_SKIP_EN
        first_push_k = 1 + COPY_CYCLES;
        exp_done     = 1 + COPY_CYCLES + exp_push.size() + bp_len;
`else
        first_push_k = 1 + COPY_CYCLES + exp_push[0];
        exp_done     = 1 + COPY_CYCLES + PHYS_REGS + bp_len;
`endif

        got_done      = -1;
        clear_cnt     = 0;
        finished      = 1'b0;
        stall_dropped = 1'b0;
        en_bad        = 1'b0;

        backup_retired_rat = test_map;
        flush_req          = 1'b1;
        fl_push_ready      = 1'b1;
        #1;
        checkOutput({name, ":stall_at_T"}, 32'(stall), 1);
        @(posedge clk); #1;
        flush_req = 1'b0;

        k = 1;
        while (k <= 300 && !finished) begin
            fl_push_ready = !(k >= first_push_k && k < first_push_k + bp_len);
            flush_req     = repulse && (k == 3);
            if (repulse && k == 3) backup_retired_rat = '0;
            if (reset_at == k) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                checkIdleOutputs({name, ":after_reset"});
                @(posedge clk); #1;
                checkOutput({name, ":idle_after_reset"}, 32'(stall), 0);
                return;
            end
            #1;
            if (!stall) stall_dropped = 1'b1;
            if (fl_clear) begin
                clear_cnt++;
                checkOutput({name, ":clear_cycle"}, 32'(k), 1);
            end
            if (rat_wr_en != '0) begin
                if (rat_wr_en != '1) en_bad = 1'b1;
                for (int l = 0; l < COPY_WIDTH; l++) got_rat[int'(rat_wr_idx[l])] = int'(rat_wr_data[l]);
            end
            if (fl_push && fl_push_ready) got_push.push_back(int'(fl_push_data));
            if (!fl_push_ready) begin
                checkOutput({name, ":bp_push_held"}, 32'(fl_push), 1);
                checkOutput({name, ":bp_data_held"}, 32'(fl_push_data), 32'(exp_push[0]));
            end
            if (recovery_done) begin
                got_done = k;
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!finished) checkOutput({name, ":timeout"}, 0, 1);

        checkOutput({name, ":done_cycle"}, 32'(got_done), 32'(exp_done));
        checkOutput({name, ":stall_held"}, 32'(stall_dropped), 0);
        checkOutput({name, ":all_lanes_en"}, 32'(en_bad), 0);
        checkOutput({name, ":clear_count"}, 32'(clear_cnt), 1);
        for (int i = 0; i < ARCH_REGS; i++) begin
            checkOutput($sformatf("%s:rat[%0d]", name, i), 32'(got_rat[i]), 32'(test_map[i]));
        end
        checkOutput({name, ":push_count"}, 32'(got_push.size()), 32'(exp_push.size()));
        for (int i = 0; i < exp_push.size() && i < got_push.size(); i++) begin
            checkOutput($sformatf("%s:push[%0d]", name, i), 32'(got_push[i]), 32'(exp_push[i]));
        end

        fl_push_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({name, ":stall_after_done"}, 32'(stall), 0);
        checkOutput({name, ":done_pulse_width"}, 32'(recovery_done), 0);
    endtask

    initial begin
        rst                = 1'b0;
        flush_req          = 1'b0;
        backup_retired_rat = '0;
        fl_push_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < ARCH_REGS; i++) test_map[i] = PW'(i);
        $display("[TB] identity map");
        applyStimulus("ident", 0, 1'b0, 0);

        test_map[5] = PW'(40);
        $display("[TB] same-cycle retire x5->40");
        applyStimulus("retire", 0, 1'b0, 0);

        test_map[5] = PW'(5);
        $display("[TB] backpressure on first push");
        applyStimulus("bp", 3, 1'b0, 0);

        $display("[TB] flush re-pulse during COPY");
        applyStimulus("repulse", 0, 1'b1, 0);

        $display("[TB] reset mid-REBUILD then full rerun");
        applyStimulus("midrst", 0, 1'b0, 20);
        applyStimulus("rerun", 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rat_recovery_seq.md
# rat_recovery_seq

Flush-recovery sequencer for the rename stage. When a mispredict retires, it snapshots the committed architectural map from the retired RAT's bypassed backup output and copies it into the speculative RAT over several cycles. It then rebuilds the physical free list by pushing every physical register not named in that snapshot. It holds rename/dispatch stalled for the whole sequence and sits between the retired RAT, the speculative RAT and the free-list FIFO.

## Interface
- SS, 2: commit width; sizes nothing internally and is kept for package consistency
- ARCH_REGS, 32: architectural registers
- PHYS_REGS, 64: physical registers; index width PW = $clog2(PHYS_REGS) = 6
- COPY_WIDTH, 4: speculative-RAT entries written per COPY cycle; must divide ARCH_REGS
- clk  in  1  clock, single domain
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising clk edge)
- flush_req  in  1  mispredicting branch retiring this cycle; single-cycle pulse
- backup_retired_rat  in  PW x ARCH_REGS  retired map including this cycle's commits
- stall  out  1  freeze rename/dispatch
- rat_wr_en  out  COPY_WIDTH  per-lane speculative-RAT write enable
- rat_wr_idx  out  5 x COPY_WIDTH  architectural index per lane
- rat_wr_data  out  PW x COPY_WIDTH  physical register per lane
- fl_clear  out  1  reset free-list pointers to empty
- fl_push  out  1  free-list push valid
- fl_push_data  out  PW  physical register pushed
- fl_push_ready  in  1  free list can accept a push
- recovery_done  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, COPY, REBUILD, DONE.
- **IDLE**
  - On flush_req=1, register backup_retired_rat into snap[ARCH_REGS] and go to COPY.
  - In the same edge, build the mapped[PHYS_REGS] bitmap from the snapshot and clear copy_ptr and scan_ptr.
- **COPY**
  - Per cycle, lane k writes rat_wr_idx = copy_ptr*COPY_WIDTH+k and rat_wr_data = snap[that index], with all lanes enabled.
  - fl_clear=1 only in the first COPY cycle.
  - After ARCH_REGS/COPY_WIDTH cycles, go to REBUILD.
- **REBUILD**, base mode (one index per cycle):
  - scan_ptr visits 0..PHYS_REGS-1.
  - If mapped[scan_ptr]=1, advance with no push.
  - Otherwise drive fl_push=1 with fl_push_data=scan_ptr, and advance only when fl_push_ready=1.
  - After the last index is consumed, go to DONE.
- **DONE**: recovery_done=1 for one cycle, then IDLE.
- stall = flush_req | (state != IDLE).
- flush_req outside IDLE is ignored; the ROB is already empty and no commits occur.
- Duplicate physical indices in the snapshot are tolerated; the bitmap is OR-based. Pushes = PHYS_REGS minus popcount(mapped).
- scan_ptr is PW+1 bits so the terminal compare does not wrap to 0.
- Reset (rst=0) in any state: next state IDLE, snapshot, bitmap and pointers cleared.

## Timing
- Reset values: stall=0, rat_wr_en=0, rat_wr_idx=0, rat_wr_data=0, fl_clear=0, fl_push=0, fl_push_data=0, recovery_done=0.
- flush_req at cycle T:
  - stall is high from T.
  - COPY runs T+1..T+8 with defaults.
  - REBUILD runs T+9..T+72 with base mode and ready held high.
  - recovery_done is at T+73; stall is low from T+74.
- Each fl_push_ready=0 cycle on a pending push adds exactly one cycle.
- A retire in cycle T is captured through the combinational bypass of the backup input.

## Configuration
- RAT_REC_SKIP_EN
  - Defined: REBUILD uses a priority encoder over ~mapped & (index >= scan_ptr). Every REBUILD cycle either pushes or is a backpressure stall, and the default config takes 32 REBUILD cycles (recovery_done at T+41).
  - Undefined: the linear one-index-per-cycle walk described above.
  - Push order (ascending index) is identical in both modes.

## Structure
- rv32i_types holds the rec_state_t enum and the ARCH_REGS, PHYS_REGS and PW constants.
- Sub-module phys_free_scanner contains the mapped bitmap, scan_ptr and the next-free selection (linear or priority-encoded). It exposes push valid/data, ready, and an end-of-scan flag.

## Test plan
- Reset with identity map: flush_req=1 with snap[i]=i → 32 COPY writes of i, pushes 32..63 in order, recovery_done at T+73 (T+41 with SKIP).
- Same-cycle retire: backup shows x5→40 at T → rat_wr_data for x5 is 40, and 40 is never pushed while 5 is pushed.
- Backpressure: fl_push_ready=0 for 3 cycles at the first push → push of 32 held stable, recovery_done delayed by exactly 3.
- flush_req re-pulsed during COPY → ignored; the snapshot and the 32-push count are unchanged.
- rst=0 mid-REBUILD → next cycle all outputs 0 and state IDLE; a new flush then runs the full sequence from index 0.
